// File: rtl/pid_loop_scheduler_pkg.sv
// Shared definitions for the PID loop scheduler: data width, one-hot FSM states and Q15 clamp.
package pid_loop_scheduler_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_SPD_REQ  = 6'b000010,
    ST_SPD_WAIT = 6'b000100,
    ST_CUR_REQ  = 6'b001000,
    ST_CUR_WAIT = 6'b010000,
    ST_OUT      = 6'b100000
  } sched_state_e;

  // Symmetric signed clamp; limit is expected to be a positive Q15 value.
  function automatic logic [DATA_WIDTH-1:0] q15Sat(input logic [DATA_WIDTH-1:0] value,
                                                   input logic [DATA_WIDTH-1:0] limit);
    logic signed [DATA_WIDTH-1:0] sVal;
    logic signed [DATA_WIDTH-1:0] sLim;
    sVal = signed'(value);
    sLim = signed'(limit);
    if (sVal > sLim) return limit;
    if (sVal < -sLim) return -limit;
    return value;
  endfunction

endpackage

// File: rtl/pid_sched_sat.sv
// Signed clamp of a Q15 value to +/-LIMIT, used to bound the iq reference.
module pid_sched_sat
  import pid_loop_scheduler_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] LIMIT = 16'h4000
) (
  input  logic [DATA_WIDTH-1:0] i_value,
  output logic [DATA_WIDTH-1:0] o_clamped
);

  assign o_clamped = q15Sat(i_value, LIMIT);

endmodule

// File: rtl/pid_loop_scheduler.sv
// Per control tick, sequences the speed PID (every SPEED_DIV ticks) then id/iq PIDs, and emits vd/vq.
// Optional wait-state watchdog: define PID_SCHED_TIMEOUT_EN.
module pid_loop_scheduler
  import pid_loop_scheduler_pkg::*;
#(
  parameter int                    SPEED_DIV      = 10,
  parameter logic [DATA_WIDTH-1:0] IQ_LIMIT       = 16'h4000,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  loop_start_in,
  input  logic                  fault_clr_in,
  input  logic [DATA_WIDTH-1:0] speed_set_in,
  input  logic [DATA_WIDTH-1:0] speed_detect_in,
  input  logic [DATA_WIDTH-1:0] id_set_in,
  input  logic [DATA_WIDTH-1:0] id_detect_in,
  input  logic [DATA_WIDTH-1:0] iq_detect_in,
  output logic                  spd_pid_en_out,
  output logic [DATA_WIDTH-1:0] spd_pid_set_out,
  output logic [DATA_WIDTH-1:0] spd_pid_det_out,
  input  logic [DATA_WIDTH-1:0] spd_pid_val_in,
  input  logic                  spd_pid_done_in,
  output logic                  id_pid_en_out,
  output logic [DATA_WIDTH-1:0] id_pid_set_out,
  output logic [DATA_WIDTH-1:0] id_pid_det_out,
  input  logic [DATA_WIDTH-1:0] id_pid_val_in,
  input  logic                  id_pid_done_in,
  output logic                  iq_pid_en_out,
  output logic [DATA_WIDTH-1:0] iq_pid_set_out,
  output logic [DATA_WIDTH-1:0] iq_pid_det_out,
  input  logic [DATA_WIDTH-1:0] iq_pid_val_in,
  input  logic                  iq_pid_done_in,
  output logic [DATA_WIDTH-1:0] iq_ref_out,
  output logic [DATA_WIDTH-1:0] vd_out,
  output logic [DATA_WIDTH-1:0] vq_out,
  output logic                  volt_valid_out,
  output logic                  busy_out,
  output logic                  overrun_out,
  output logic                  timeout_out
);

  localparam int               DIV_W    = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);

  sched_state_e          r_state;
  sched_state_e          w_nextState;
  logic [DIV_W-1:0]      r_divCnt;
  logic                  r_idGot;
  logic                  r_iqGot;
  logic [DATA_WIDTH-1:0] r_idVal;
  logic [DATA_WIDTH-1:0] r_iqVal;
  logic [DATA_WIDTH-1:0] w_spdClamped;
  logic [DATA_WIDTH-1:0] w_idRes;
  logic [DATA_WIDTH-1:0] w_iqRes;
  logic                  w_curDone;
  logic                  w_tickAccept;
  logic                  w_expired;

  pid_sched_sat #(.LIMIT(IQ_LIMIT)) u_iqRefSat (
    .i_value  (spd_pid_val_in),
    .o_clamped(w_spdClamped)
  );

  // A result arriving this cycle counts as latched so same-cycle dones finish together.
  assign w_idRes      = id_pid_done_in ? id_pid_val_in : r_idVal;
  assign w_iqRes      = iq_pid_done_in ? iq_pid_val_in : r_iqVal;
  assign w_curDone    = (r_idGot | id_pid_done_in) & (r_iqGot | iq_pid_done_in);
  assign w_tickAccept = (r_state == ST_IDLE) & loop_start_in;

`ifdef PID_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_waitCnt;
  logic            w_inWait;

  assign w_inWait  = (r_state == ST_SPD_WAIT) | (r_state == ST_CUR_WAIT);
  assign w_expired = w_inWait & (r_waitCnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_waitCnt   <= '0;
      timeout_out <= 1'b0;
    end else begin
      r_waitCnt   <= (w_inWait && (w_nextState == r_state)) ? r_waitCnt + 1'b1 : '0;
      timeout_out <= (w_expired && (w_nextState == ST_IDLE)) | (timeout_out & ~fault_clr_in);
    end
  end
`else
  assign w_expired   = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState    = r_state;
    spd_pid_en_out = 1'b0;
    id_pid_en_out  = 1'b0;
    iq_pid_en_out  = 1'b0;
    volt_valid_out = 1'b0;
    busy_out       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (loop_start_in) w_nextState = (r_divCnt == '0) ? ST_SPD_REQ : ST_CUR_REQ;
      end
      ST_SPD_REQ: begin
        spd_pid_en_out = 1'b1;
        w_nextState    = ST_SPD_WAIT;
      end
      ST_SPD_WAIT: begin
        if (spd_pid_done_in) w_nextState = ST_CUR_REQ;
        else if (w_expired)  w_nextState = ST_IDLE;
      end
      ST_CUR_REQ: begin
        id_pid_en_out = 1'b1;
        iq_pid_en_out = 1'b1;
        w_nextState   = ST_CUR_WAIT;
      end
      ST_CUR_WAIT: begin
        if (w_curDone)      w_nextState = ST_OUT;
        else if (w_expired) w_nextState = ST_IDLE;
      end
      ST_OUT: begin
        volt_valid_out = 1'b1;
        w_nextState    = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The set/det output registers double as the tick-time capture of the measurements.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_divCnt        <= '0;
      r_idGot         <= 1'b0;
      r_iqGot         <= 1'b0;
      r_idVal         <= '0;
      r_iqVal         <= '0;
      spd_pid_set_out <= '0;
      spd_pid_det_out <= '0;
      id_pid_set_out  <= '0;
      id_pid_det_out  <= '0;
      iq_pid_set_out  <= '0;
      iq_pid_det_out  <= '0;
      iq_ref_out      <= '0;
      vd_out          <= '0;
      vq_out          <= '0;
      overrun_out     <= 1'b0;
    end else begin
      if (w_tickAccept) begin
        r_divCnt        <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + 1'b1;
        spd_pid_set_out <= speed_set_in;
        spd_pid_det_out <= speed_detect_in;
        id_pid_set_out  <= id_set_in;
        id_pid_det_out  <= id_detect_in;
        iq_pid_set_out  <= iq_ref_out;
        iq_pid_det_out  <= iq_detect_in;
      end
      if ((r_state == ST_SPD_WAIT) && spd_pid_done_in) begin
        iq_ref_out     <= w_spdClamped;
        iq_pid_set_out <= w_spdClamped;
      end
      if (r_state == ST_CUR_REQ) begin
        r_idGot <= 1'b0;
        r_iqGot <= 1'b0;
      end
      if (r_state == ST_CUR_WAIT) begin
        if (id_pid_done_in) begin
          r_idGot <= 1'b1;
          r_idVal <= id_pid_val_in;
        end
        if (iq_pid_done_in) begin
          r_iqGot <= 1'b1;
          r_iqVal <= iq_pid_val_in;
        end
        if (w_curDone) begin
          vd_out <= w_idRes;
          vq_out <= w_iqRes;
        end
      end
      overrun_out <= (loop_start_in && (r_state != ST_IDLE)) | (overrun_out & ~fault_clr_in);
    end
  end

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Self-checking bench for pid_loop_scheduler: randomized ticks against a behavioural model of the sequence.
module tb_pid_loop_scheduler;

  localparam int SPEED_DIV = 10;

  logic        sys_clk;
  logic        reset_n;
  logic        loop_start_in;
  logic        fault_clr_in;
  logic [15:0] speed_set_in;
  logic [15:0] speed_detect_in;
  logic [15:0] id_set_in;
  logic [15:0] id_detect_in;
  logic [15:0] iq_detect_in;
  logic        spd_pid_en_out;
  logic [15:0] spd_pid_set_out;
  logic [15:0] spd_pid_det_out;
  logic [15:0] spd_pid_val_in;
  logic        spd_pid_done_in;
  logic        id_pid_en_out;
  logic [15:0] id_pid_set_out;
  logic [15:0] id_pid_det_out;
  logic [15:0] id_pid_val_in;
  logic        id_pid_done_in;
  logic        iq_pid_en_out;
  logic [15:0] iq_pid_set_out;
  logic [15:0] iq_pid_det_out;
  logic [15:0] iq_pid_val_in;
  logic        iq_pid_done_in;
  logic [15:0] iq_ref_out;
  logic [15:0] vd_out;
  logic [15:0] vq_out;
  logic        volt_valid_out;
  logic        busy_out;
  logic        overrun_out;
  logic        timeout_out;

  // Reference model state: tick counter, expected clamped reference, voltages and flags.
  int          checks = 0;
  int          failures = 0;
  int          tickIdx = 0;
  logic [15:0] expIqRef = '0;
  logic [15:0] expVd = '0;
  logic [15:0] expVq = '0;
  logic        expOverrun = 1'b0;
  logic [15:0] capSpdSet, capSpdDet, capIdSet, capIdDet, capIqDet;

  pid_loop_scheduler #(
    .SPEED_DIV(SPEED_DIV),
    .IQ_LIMIT(16'h4000),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .loop_start_in(loop_start_in),
    .fault_clr_in(fault_clr_in),
    .speed_set_in(speed_set_in),
    .speed_detect_in(speed_detect_in),
    .id_set_in(id_set_in),
    .id_detect_in(id_detect_in),
    .iq_detect_in(iq_detect_in),
    .spd_pid_en_out(spd_pid_en_out),
    .spd_pid_set_out(spd_pid_set_out),
    .spd_pid_det_out(spd_pid_det_out),
    .spd_pid_val_in(spd_pid_val_in),
    .spd_pid_done_in(spd_pid_done_in),
    .id_pid_en_out(id_pid_en_out),
    .id_pid_set_out(id_pid_set_out),
    .id_pid_det_out(id_pid_det_out),
    .id_pid_val_in(id_pid_val_in),
    .id_pid_done_in(id_pid_done_in),
    .iq_pid_en_out(iq_pid_en_out),
    .iq_pid_set_out(iq_pid_set_out),
    .iq_pid_det_out(iq_pid_det_out),
    .iq_pid_val_in(iq_pid_val_in),
    .iq_pid_done_in(iq_pid_done_in),
    .iq_ref_out(iq_ref_out),
    .vd_out(vd_out),
    .vq_out(vq_out),
    .volt_valid_out(volt_valid_out),
    .busy_out(busy_out),
    .overrun_out(overrun_out),
    .timeout_out(timeout_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Global safety net so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout observed=stuck expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge sys_clk);
    #1;
  endtask

  // Saturation expressed in plain integer arithmetic, limit 16384.
  function automatic logic [15:0] clampRef(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s > 16384) return 16'h4000;
    if (s < -16384) return 16'hC000;
    return v;
  endfunction

  task automatic randomizeInputs();
    speed_set_in    = 16'($urandom);
    speed_detect_in = 16'($urandom);
    id_set_in       = 16'($urandom);
    id_detect_in    = 16'($urandom);
    iq_detect_in    = 16'($urandom);
  endtask

  // Pulse one tick from IDLE; inputs are scrambled afterwards so only the capture can match.
  task automatic startTick(output bit expSpeed);
    randomizeInputs();
    capSpdSet = speed_set_in;
    capSpdDet = speed_detect_in;
    capIdSet  = id_set_in;
    capIdDet  = id_detect_in;
    capIqDet  = iq_detect_in;
    loop_start_in = 1'b1;
    stepClk();
    loop_start_in = 1'b0;
    randomizeInputs();
    expSpeed = ((tickIdx % SPEED_DIV) == 0);
    tickIdx++;
  endtask

  task automatic speedPhase(input logic [15:0] spdVal, input int delay, input bit injectTick, input bit clrWithTick);
    checkOutput("spdSet", spd_pid_set_out, capSpdSet);
    checkOutput("spdDet", spd_pid_det_out, capSpdDet);
    stepClk();
    checkOutput("spdEnPulse", spd_pid_en_out, 1'b0);
    for (int c = 1; c <= delay; c++) begin
      spd_pid_done_in = (c == delay);
      spd_pid_val_in  = (c == delay) ? spdVal : 16'($urandom);
      if (c == 1 && injectTick) begin
        loop_start_in = 1'b1;
        fault_clr_in  = clrWithTick;
        expOverrun    = 1'b1;
      end
      stepClk();
      spd_pid_done_in = 1'b0;
      loop_start_in   = 1'b0;
      fault_clr_in    = 1'b0;
    end
    expIqRef = clampRef(spdVal);
    checkOutput("iqRef", iq_ref_out, expIqRef);
  endtask

  task automatic currentPhase(input logic [15:0] idVal, input logic [15:0] iqVal, input int idDelay,
                              input int iqDelay, input bit injectTick, input bit clrWithTick);
    int maxD;
    maxD = (idDelay > iqDelay) ? idDelay : iqDelay;
    checkOutput("idEn", id_pid_en_out, 1'b1);
    checkOutput("iqEn", iq_pid_en_out, 1'b1);
    checkOutput("idSet", id_pid_set_out, capIdSet);
    checkOutput("idDet", id_pid_det_out, capIdDet);
    checkOutput("iqSet", iq_pid_set_out, expIqRef);
    checkOutput("iqDet", iq_pid_det_out, capIqDet);
    stepClk();
    for (int c = 1; c <= maxD; c++) begin
      id_pid_done_in = (c == idDelay);
      id_pid_val_in  = (c == idDelay) ? idVal : 16'($urandom);
      iq_pid_done_in = (c == iqDelay);
      iq_pid_val_in  = (c == iqDelay) ? iqVal : 16'($urandom);
      if (c == 1 && injectTick) begin
        loop_start_in = 1'b1;
        fault_clr_in  = clrWithTick;
        expOverrun    = 1'b1;
      end
      stepClk();
      id_pid_done_in = 1'b0;
      iq_pid_done_in = 1'b0;
      loop_start_in  = 1'b0;
      fault_clr_in   = 1'b0;
      if (c < maxD) checkOutput("earlyValid", volt_valid_out, 1'b0);
    end
    expVd = idVal;
    expVq = iqVal;
    checkOutput("voltValid", volt_valid_out, 1'b1);
    checkOutput("vd", vd_out, expVd);
    checkOutput("vq", vq_out, expVq);
    stepClk();
    checkOutput("validSingle", volt_valid_out, 1'b0);
    checkOutput("idleAfterOut", busy_out, 1'b0);
  endtask

  // One full control tick through speed (if due) and current loops.
  task automatic applyStimulus(input logic [15:0] spdVal, input logic [15:0] idVal, input logic [15:0] iqVal,
                               input int spdDelay, input int idDelay, input int iqDelay,
                               input bit injectTick, input bit clrWithTick);
    bit expSpeed;
    startTick(expSpeed);
    checkOutput("spdEnOnTick", spd_pid_en_out, expSpeed);
    if (expSpeed) speedPhase(spdVal, spdDelay, injectTick, clrWithTick);
    currentPhase(idVal, iqVal, idDelay, iqDelay, injectTick && !expSpeed, clrWithTick);
    checkOutput("overrun", overrun_out, expOverrun);
    checkOutput("timeoutQuiet", timeout_out, 1'b0);
  endtask

  task automatic resetModel();
    tickIdx    = 0;
    expIqRef   = '0;
    expVd      = '0;
    expVq      = '0;
    expOverrun = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Busy"}, busy_out, 1'b0);
    checkOutput({tag, "SpdEn"}, spd_pid_en_out, 1'b0);
    checkOutput({tag, "IdEn"}, id_pid_en_out, 1'b0);
    checkOutput({tag, "IqEn"}, iq_pid_en_out, 1'b0);
    checkOutput({tag, "Valid"}, volt_valid_out, 1'b0);
    checkOutput({tag, "IqRef"}, iq_ref_out, 16'h0000);
    checkOutput({tag, "Vd"}, vd_out, 16'h0000);
    checkOutput({tag, "Vq"}, vq_out, 16'h0000);
    checkOutput({tag, "IqSet"}, iq_pid_set_out, 16'h0000);
    checkOutput({tag, "IdDet"}, id_pid_det_out, 16'h0000);
    checkOutput({tag, "Overrun"}, overrun_out, 1'b0);
    checkOutput({tag, "Timeout"}, timeout_out, 1'b0);
  endtask

  initial begin
    bit          sp;
    bit          sawValid;
    logic [15:0] toId;
    logic [15:0] toIq;

    reset_n         = 1'b0;
    loop_start_in   = 1'b0;
    fault_clr_in    = 1'b0;
    spd_pid_done_in = 1'b0;
    id_pid_done_in  = 1'b0;
    iq_pid_done_in  = 1'b0;
    spd_pid_val_in  = '0;
    id_pid_val_in   = '0;
    iq_pid_val_in   = '0;
    randomizeInputs();
    repeat (3) stepClk();
    checkAllZero("reset");
    reset_n = 1'b1;
    resetModel();
    stepClk();

    $display("[TB] divider and clamp sequence");
    for (int i = 0; i < 20; i++) begin
      logic [15:0] sv, iv, qv;
      int dId, dIq;
      sv  = (i == 0) ? 16'h6000 : (i == 10) ? 16'h9000 : 16'($urandom);
      iv  = (i == 0) ? 16'h0123 : 16'($urandom);
      qv  = (i == 0) ? 16'h0456 : 16'($urandom);
      dId = $urandom_range(1, 5);
      dIq = ((i % 4) == 1) ? dId : $urandom_range(1, 5);
      applyStimulus(sv, iv, qv, $urandom_range(1, 5), dId, dIq, 1'b0, 1'b0);
      if (i == 0) checkOutput("firstIqRef", iq_ref_out, 16'h4000);
      if (i == 10) checkOutput("negIqRef", iq_ref_out, 16'hC000);
    end

    $display("[TB] overrun handling");
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 3, 2, 4, 1'b1, 1'b0);
    fault_clr_in = 1'b1;
    stepClk();
    fault_clr_in = 1'b0;
    expOverrun   = 1'b0;
    checkOutput("overrunClr", overrun_out, expOverrun);
    for (int i = 21; i < 29; i++)
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 2, 3, 3, 1'b0, 1'b0);
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 2, 3, 1, 1'b1, 1'b1);
    fault_clr_in = 1'b1;
    stepClk();
    fault_clr_in = 1'b0;
    expOverrun   = 1'b0;
    checkOutput("overrunClr2", overrun_out, expOverrun);
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 4, 1, 2, 1'b0, 1'b0);

    $display("[TB] stray dones while idle");
    spd_pid_done_in = 1'b1;
    spd_pid_val_in  = 16'h7FFF;
    id_pid_done_in  = 1'b1;
    id_pid_val_in   = 16'h1111;
    iq_pid_done_in  = 1'b1;
    iq_pid_val_in   = 16'h2222;
    stepClk();
    spd_pid_done_in = 1'b0;
    id_pid_done_in  = 1'b0;
    iq_pid_done_in  = 1'b0;
    stepClk();
    checkOutput("strayIqRef", iq_ref_out, expIqRef);
    checkOutput("strayVd", vd_out, expVd);
    checkOutput("strayVq", vq_out, expVq);
    checkOutput("strayValid", volt_valid_out, 1'b0);
    checkOutput("strayBusy", busy_out, 1'b0);

    $display("[TB] reset during current wait");
    startTick(sp);
    if (sp) speedPhase(16'($urandom), 2, 1'b0, 1'b0);
    stepClk();
    id_pid_done_in = 1'b1;
    id_pid_val_in  = 16'($urandom);
    stepClk();
    id_pid_done_in = 1'b0;
    stepClk();
    checkOutput("preResetBusy", busy_out, 1'b1);
    reset_n = 1'b0;
    stepClk();
    checkAllZero("midReset");
    reset_n = 1'b1;
    resetModel();
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 2, 2, 3, 1'b0, 1'b0);

    $display("[TB] withheld iq done");
    toId = 16'($urandom);
    toIq = 16'($urandom);
    startTick(sp);
    checkOutput("wdSpdSkip", spd_pid_en_out, sp);
    checkOutput("wdIdEn", id_pid_en_out, 1'b1);
    stepClk();
    id_pid_done_in = 1'b1;
    id_pid_val_in  = toId;
    stepClk();
    id_pid_done_in = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      stepClk();
      if (volt_valid_out) sawValid = 1'b1;
    end
    checkOutput("wdNoValid", sawValid, 1'b0);
`ifdef PID_SCHED_TIMEOUT_EN
    checkOutput("wdIdle", busy_out, 1'b0);
    checkOutput("wdTimeout", timeout_out, 1'b1);
    checkOutput("wdVd", vd_out, expVd);
    checkOutput("wdVq", vq_out, expVq);
    checkOutput("wdIqRef", iq_ref_out, expIqRef);
    fault_clr_in = 1'b1;
    stepClk();
    fault_clr_in = 1'b0;
    checkOutput("wdTimeoutClr", timeout_out, 1'b0);
`else
    checkOutput("wdStillBusy", busy_out, 1'b1);
    checkOutput("wdTimeoutTied", timeout_out, 1'b0);
    iq_pid_done_in = 1'b1;
    iq_pid_val_in  = toIq;
    stepClk();
    iq_pid_done_in = 1'b0;
    expVd = toId;
    expVq = toIq;
    checkOutput("wdLateValid", volt_valid_out, 1'b1);
    checkOutput("wdLateVd", vd_out, expVd);
    checkOutput("wdLateVq", vq_out, expVq);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
